// File: rtl/xbus_mcast_sched.sv
`default_nettype none
// ============================================================================
// Module   : xbus_mcast_sched
// Purpose  : Tag-based multicast scheduler for the PE-array row bus. Takes one
//            packet at a time, matches its row/column IDs against per-PE tag
//            registers, waits until every matched PE is ready and then delivers
//            the packet to all of them in a single bus beat.
// Ports    : clk, rstn (sync, active-high)
//            in_valid/in_ready/in_data/in_row_id/in_col_id/in_last - packet in
//            cfg_we/cfg_is_col/cfg_addr/cfg_tag                     - tag writes
//            flush                                                  - abort
//            pe_ready[N] / pe_enable[N]                             - PE handshake
//            bus_valid/bus_data                                     - bus beat
//            busy/done/err_nomatch/pkt_cnt                          - status
// Revision : 1.0 - initial release
// ============================================================================
module xbus_mcast_sched #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_ROW    = 4,
    parameter  int NUM_COL    = 4,
    parameter  int ID_WIDTH   = 4,
    localparam int N          = NUM_ROW * NUM_COL,
    localparam int AW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_row_id,
    input  logic [ID_WIDTH-1:0]   in_col_id,
    input  logic                  in_last,
    input  logic                  cfg_we,
    input  logic                  cfg_is_col,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [ID_WIDTH-1:0]   cfg_tag,
    input  logic                  flush,
    input  logic [N-1:0]          pe_ready,
    output logic [N-1:0]          pe_enable,
    output logic                  bus_valid,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_nomatch,
    output logic [15:0]           pkt_cnt
);

    localparam logic [ID_WIDTH-1:0] C_WILDCARD = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MATCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   row_id_q;
    logic [ID_WIDTH-1:0]   col_id_q;
    logic                  last_q;
    logic [N-1:0]          mask_q;
    logic                  err_q;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic [ID_WIDTH-1:0]   row_tag_q [NUM_ROW];
    logic [ID_WIDTH-1:0]   col_tag_q [N];

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_drop;
    logic                  w_beat;
    logic [N-1:0]          w_mask;

    // ------------------------------------------------------------------------
    // Target match: each PE compares the held IDs against its own row tag
    // (shared by the whole row) and its private column tag.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N; i++) begin : g_pe_match
            localparam int R = i / NUM_COL;
            assign w_mask[i] = ((row_id_q == C_WILDCARD) || (row_id_q == row_tag_q[R])) &&
                               ((col_id_q == C_WILDCARD) || (col_id_q == col_tag_q[i]));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_fire   = 1'b0;
        w_drop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_accept = 1'b1;
                    state_d  = S_MATCH;
                end
            end
            S_MATCH: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (w_mask == '0) begin
                    w_drop  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Only matched PEs gate the beat; flush takes priority over it.
                if (flush) begin
                    state_d = S_IDLE;
                end else if ((pe_ready & mask_q) == mask_q) begin
                    w_fire  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pkt_cnt_d = pkt_cnt_q + {15'd0, w_fire};

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            row_id_q  <= '0;
            col_id_q  <= '0;
            last_q    <= 1'b0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= w_drop;
            pkt_cnt_q <= pkt_cnt_d;
            if (w_accept) begin
                data_q   <= in_data;
                row_id_q <= in_row_id;
                col_id_q <= in_col_id;
                last_q   <= in_last;
            end
            if (state_q == S_MATCH) begin
                mask_q <= w_mask;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag registers. A write landing on the MATCH edge is not seen by the
    // mask registered on that same edge, so it takes effect from the next
    // packet. Row addresses beyond NUM_ROW match no register and are dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                row_tag_q[r] <= ID_WIDTH'(r);
            end
            for (int i = 0; i < N; i++) begin
                col_tag_q[i] <= ID_WIDTH'(i % NUM_COL);
            end
        end else if (cfg_we) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                if (!cfg_is_col && (cfg_addr == AW'(r))) begin
                    row_tag_q[r] <= cfg_tag;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (cfg_is_col && (cfg_addr == AW'(i))) begin
                    col_tag_q[i] <= cfg_tag;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Reset masks everything immediately so nothing leaks out during
    // the reset cycle, including a beat that would otherwise fire mid-ISSUE.
    // ------------------------------------------------------------------------
    assign w_beat      = w_fire && !rstn;
    assign in_ready    = (state_q == S_IDLE) && !flush && !rstn;
    assign bus_valid   = w_beat;
    assign pe_enable   = w_beat ? mask_q : '0;
    assign bus_data    = w_beat ? data_q : '0;
    assign done        = w_beat && last_q;
    assign busy        = (state_q != S_IDLE) && !rstn;
    assign err_nomatch = err_q && !rstn;
    assign pkt_cnt     = rstn ? 16'd0 : pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xbus_mcast_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbus_mcast_sched
// Purpose  : Self-checking bench for xbus_mcast_sched. Directed scenarios plus
//            randomized packets/tag writes checked against a transaction-level
//            reference model (tag arrays, expected target set, packet count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbus_mcast_sched;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int IW = 4;
    localparam int NP = NR * NC;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_row_id;
    logic [IW-1:0] in_col_id;
    logic          in_last;
    logic          cfg_we;
    logic          cfg_is_col;
    logic [3:0]    cfg_addr;
    logic [IW-1:0] cfg_tag;
    logic          flush;
    logic [NP-1:0] pe_ready;
    logic [NP-1:0] pe_enable;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic          busy;
    logic          done;
    logic          err_nomatch;
    logic [15:0]   pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [IW-1:0] m_rt [NR];
    logic [IW-1:0] m_ct [NP];
    logic [15:0]   m_cnt;

    xbus_mcast_sched #(
        .DATA_WIDTH (DW),
        .NUM_ROW    (NR),
        .NUM_COL    (NC),
        .ID_WIDTH   (IW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_row_id   (in_row_id),
        .in_col_id   (in_col_id),
        .in_last     (in_last),
        .cfg_we      (cfg_we),
        .cfg_is_col  (cfg_is_col),
        .cfg_addr    (cfg_addr),
        .cfg_tag     (cfg_tag),
        .flush       (flush),
        .pe_ready    (pe_ready),
        .pe_enable   (pe_enable),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .busy        (busy),
        .done        (done),
        .err_nomatch (err_nomatch),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at +4.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rt[r] = IW'(r);
        for (int i = 0; i < NP; i++) m_ct[i] = IW'(i % NC);
        m_cnt = 16'd0;
    endtask

    task automatic model_cfg(input logic is_col, input logic [3:0] addr, input logic [IW-1:0] tag);
        if (is_col) m_ct[addr] = tag;
        else if (int'(addr) < NR) m_rt[addr] = tag;
    endtask

    // Set of PEs a packet targets: row tag of PE's row and its own column tag,
    // each satisfied by an exact hit or the all-ones wildcard.
    function automatic logic [NP-1:0] exp_mask(input logic [IW-1:0] row, input logic [IW-1:0] col);
        logic [NP-1:0] m;
        m = '0;
        for (int i = 0; i < NP; i++) begin
            if ((row == 4'hF || row == m_rt[i / NC]) && (col == 4'hF || col == m_ct[i]))
                m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic cfg_write(input logic is_col, input logic [3:0] addr, input logic [IW-1:0] tag);
        cfg_we = 1'b1; cfg_is_col = is_col; cfg_addr = addr; cfg_tag = tag;
        step();
        cfg_we = 1'b0;
        model_cfg(is_col, addr, tag);
    endtask

    // Full packet transaction. 'hold' cycles keep the highest matched PE not
    // ready before the beat. Optionally issues a tag write during MATCH.
    task automatic send(input logic [IW-1:0] row, input logic [IW-1:0] col,
                        input logic [DW-1:0] data, input logic last, input int hold,
                        input bit mid_cfg, input logic mc_col, input logic [3:0] mc_addr,
                        input logic [IW-1:0] mc_tag);
        logic [NP-1:0] m;
        int hb;
        m = exp_mask(row, col);
        hb = 0;
        for (int i = 0; i < NP; i++) if (m[i]) hb = i;
        // accept cycle
        in_valid = 1'b1; in_data = data; in_row_id = row; in_col_id = col; in_last = last;
        pe_ready = NP'($urandom);
        #4;
        check("accept_in_ready", in_ready, 1);
        check("accept_busy", busy, 0);
        step();
        // MATCH cycle
        in_valid = 1'b0; in_data = DW'($urandom); in_row_id = IW'($urandom); in_last = ~last;
        if (mid_cfg) begin
            cfg_we = 1'b1; cfg_is_col = mc_col; cfg_addr = mc_addr; cfg_tag = mc_tag;
        end
        #4;
        check("match_busy", busy, 1);
        check("match_no_beat", bus_valid, 0);
        step();
        if (mid_cfg) begin
            cfg_we = 1'b0;
            model_cfg(mc_col, mc_addr, mc_tag);
        end
        if (m == '0) begin
            #4;
            check("drop_err", err_nomatch, 1);
            check("drop_no_beat", bus_valid, 0);
            check("drop_busy", busy, 0);
            check("drop_cnt", pkt_cnt, m_cnt);
            step();
            #4;
            check("drop_err_clear", err_nomatch, 0);
            step();
        end else begin
            for (int k = 0; k < hold; k++) begin
                pe_ready = NP'($urandom) & ~(NP'(1) << hb);
                #4;
                check("wait_no_beat", bus_valid, 0);
                check("wait_pe_enable", pe_enable, 0);
                check("wait_bus_data", bus_data, 0);
                check("wait_busy", busy, 1);
                step();
            end
            pe_ready = NP'($urandom) | m;
            #4;
            check("beat_valid", bus_valid, 1);
            check("beat_pe_enable", pe_enable, m);
            check("beat_data", bus_data, data);
            check("beat_done", done, last);
            check("beat_err", err_nomatch, 0);
            check("beat_cnt_before", pkt_cnt, m_cnt);
            m_cnt = m_cnt + 16'd1;
            step();
            #4;
            check("post_busy", busy, 0);
            check("post_valid", bus_valid, 0);
            check("post_done", done, 0);
            check("post_cnt", pkt_cnt, m_cnt);
            step();
        end
    endtask

    initial begin
        logic [IW-1:0] rr, cc;
        rstn = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_row_id = '0; in_col_id = '0;
        in_last = 1'b0; cfg_we = 1'b0; cfg_is_col = 1'b0; cfg_addr = '0; cfg_tag = '0;
        flush = 1'b0; pe_ready = '1;
        model_reset();
        #1;
        #4;
        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_pe_enable", pe_enable, 0);
        check("rst_bus_data", bus_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_nomatch, 0);
        check("rst_cnt", pkt_cnt, 0);
        step();
        step();
        rstn = 1'b0; in_valid = 1'b0;
        #4;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        step();

        // Single-target delivery
        send(4'd1, 4'd2, 16'h1234, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
        // Column multicast, one PE stalls the beat
        send(4'hF, 4'd3, 16'hA5A5, 1'b0, 5, 1'b0, 1'b0, 4'd0, 4'd0);
        // Retagged row: old ID drops, new ID hits
        cfg_write(1'b0, 4'd2, 4'hA);
        send(4'd2, 4'd0, 16'h0BAD, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
        send(4'hA, 4'd0, 16'h600D, 1'b0, 1, 1'b0, 1'b0, 4'd0, 4'd0);
        // Out-of-range row address is ignored
        cfg_write(1'b0, 4'd9, 4'd7);
        send(4'd3, 4'd1, 16'h3131, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

        // flush coincident with the issue condition
        in_valid = 1'b1; in_row_id = 4'hF; in_col_id = 4'hF; in_data = 16'h7777; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        pe_ready = '1; flush = 1'b1;
        #4;
        check("flush_no_beat", bus_valid, 0);
        check("flush_pe_enable", pe_enable, 0);
        check("flush_bus_data", bus_data, 0);
        check("flush_done", done, 0);
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        #4;
        check("flush_busy", busy, 0);
        check("flush_in_ready_after", in_ready, 1);
        check("flush_cnt", pkt_cnt, m_cnt);
        step();
        // flush during MATCH of an unmatched packet: no error pulse
        in_valid = 1'b1; in_row_id = 4'hE; in_col_id = 4'hE;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        #4;
        check("flush_match_err", err_nomatch, 0);
        check("flush_match_busy", busy, 0);
        step();

        // Tile of three packets; done only on the last
        send(4'd0, 4'd0, 16'h0001, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
        send(4'd1, 4'hF, 16'h0002, 1'b0, 2, 1'b0, 1'b0, 4'd0, 4'd0);
        send(4'hF, 4'hF, 16'h0003, 1'b1, 0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Counter wrap: preload the counter to all-ones while idle
        force dut.pkt_cnt_d = 16'hFFFF;
        step();
        release dut.pkt_cnt_d;
        m_cnt = 16'hFFFF;
        #4;
        check("preload_cnt", pkt_cnt, 16'hFFFF);
        step();
        send(4'd0, 4'd1, 16'hCAFE, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("wrap_model", {16'd0, m_cnt}, 0);

        // Reset while waiting in ISSUE
        in_valid = 1'b1; in_row_id = 4'd1; in_col_id = 4'd2; in_data = 16'h5555; in_last = 1'b1;
        pe_ready = '0;
        step();
        in_valid = 1'b0;
        step();
        #4;
        check("rst_issue_wait", bus_valid, 0);
        step();
        rstn = 1'b1; pe_ready = '1;
        #4;
        check("rst_issue_valid", bus_valid, 0);
        check("rst_issue_pe_enable", pe_enable, 0);
        check("rst_issue_data", bus_data, 0);
        check("rst_issue_done", done, 0);
        check("rst_issue_busy", busy, 0);
        check("rst_issue_cnt", pkt_cnt, 0);
        check("rst_issue_in_ready", in_ready, 0);
        step();
        rstn = 1'b0;
        model_reset();
        #4;
        check("rst_issue_after_busy", busy, 0);
        step();
        send(4'd1, 4'd1, 16'h0505, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Tag write during MATCH uses the old tag for that packet
        send(4'd1, 4'd1, 16'h1111, 1'b0, 0, 1'b1, 1'b0, 4'd1, 4'd5);
        send(4'd5, 4'd1, 16'h2222, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          IW'($urandom_range(0, 5)));
            rr = ($urandom_range(0, 4) == 0) ? 4'hF : IW'($urandom_range(0, 5));
            cc = ($urandom_range(0, 4) == 0) ? 4'hF : IW'($urandom_range(0, 4));
            send(rr, cc, DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), IW'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
